// File: rtl/gol_pkg.sv
// Shared types, default geometry and index helpers for the Game of Life generation scheduler.
package gol_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StEval,
    StSwap
  } gol_state_e;

  localparam int unsigned DefWidth        = 3;
  localparam int unsigned DefHeight       = 3;
  localparam int unsigned DefFramesPerGen = 60;

  // True when a signed coordinate lies on a board axis of n cells.
  function automatic logic in_range(input int v, input int n);
    return (v >= 0) && (v < n);
  endfunction

  function automatic logic gol_rule(input logic live, input logic [3:0] n);
    return (n == 4'd3) || (live && (n == 4'd2));
  endfunction

endpackage

// File: rtl/gol_cell_rule.sv
// Combinational 3x3 neighbourhood gather, neighbour count and next-state for one cell.
// GOL_WRAP_EN selects a toroidal board; otherwise off-board neighbours are dead.
module gol_cell_rule
  import gol_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned HEIGHT = DefHeight
) (
  input  logic [(1 << (WIDTH + HEIGHT))-1:0] board,
  input  logic [WIDTH+HEIGHT-1:0]            idx,
  output logic                               next_state
);

  localparam int unsigned AW   = WIDTH + HEIGHT;
  localparam int          COLS = 1 << WIDTH;
  localparam int          ROWS = 1 << HEIGHT;

  logic [8:0]    nbhd;
  logic [3:0]    count;
  logic [AW-1:0] nidx;
  logic          valid;
  int            row, col, r, c;

  always_comb begin
    nbhd  = '0;
    count = '0;
    nidx  = '0;
    valid = 1'b0;
    r     = 0;
    c     = 0;
    row   = int'(idx[AW-1:WIDTH]);
    col   = int'(idx[WIDTH-1:0]);
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        r = row + dr - 1;
        c = col + dc - 1;
        // Truncating the coordinates gives the modulo wrap for free.
        nidx = {r[HEIGHT-1:0], c[WIDTH-1:0]};
`ifdef GOL_WRAP_EN
        valid = 1'b1;
`else
        valid = in_range(r, ROWS) && in_range(c, COLS);
`endif
        nbhd[dr*3+dc] = valid & board[nidx];
      end
    end
    for (int k = 0; k < 9; k++) begin
      if (k != 4) count = count + {3'b000, nbhd[k]};
    end
    next_state = gol_rule(nbhd[4], count);
  end

endmodule

// File: rtl/gol_gen_scheduler.sv
// Double-buffered Game of Life generation sequencer: frame pacing, per-cell evaluation, swap.
// Build macro GOL_WRAP_EN (passed to gol_cell_rule) makes the board toroidal.
module gol_gen_scheduler
  import gol_pkg::*;
#(
  parameter int unsigned                      WIDTH          = DefWidth,
  parameter int unsigned                      HEIGHT         = DefHeight,
  parameter int unsigned                      FRAMES_PER_GEN = DefFramesPerGen,
  parameter logic [(1 << (WIDTH+HEIGHT))-1:0] SEED           = 'h8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_tick,
  input  logic                    run,
  input  logic                    step,
  input  logic                    load_en,
  input  logic [WIDTH+HEIGHT-1:0] load_addr,
  input  logic                    load_data,
  input  logic [WIDTH+HEIGHT-1:0] rd_addr,
  output logic                    rd_data,
  output logic                    busy,
  output logic                    gen_done,
  output logic [15:0]             gen_count
);

  localparam int unsigned AW   = WIDTH + HEIGHT;
  localparam int unsigned SIZE = 1 << AW;
  localparam int unsigned FcW  = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

  gol_state_e     state_q, state_d;
  logic [SIZE-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic            sel_q, sel_d;
  logic [FcW-1:0]  frame_cnt_q, frame_cnt_d;
  logic [AW-1:0]   cell_idx_q, cell_idx_d;
  logic [15:0]     gen_count_q, gen_count_d;
  logic [SIZE-1:0] front;
  logic            next_cell;

  assign front     = sel_q ? buf1_q : buf0_q;
  assign rd_data   = front[rd_addr];
  assign busy      = (state_q == StEval) || (state_q == StSwap);
  assign gen_done  = (state_q == StSwap);
  assign gen_count = gen_count_q;

  gol_cell_rule #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_cell_rule (
    .board     (front),
    .idx       (cell_idx_q),
    .next_state(next_cell)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    frame_cnt_d = frame_cnt_q;
    cell_idx_d  = cell_idx_q;
    gen_count_d = gen_count_q;
    unique case (state_q)
      StIdle: begin
        frame_cnt_d = '0;
        cell_idx_d  = '0;
        if (run) state_d = StWait;
        else if (step) state_d = StEval;
      end
      StWait: begin
        cell_idx_d = '0;
        if (!run) begin
          state_d     = StIdle;
          frame_cnt_d = '0;
        end else if (frame_tick) begin
          if (frame_cnt_q == FcW'(FRAMES_PER_GEN - 1)) begin
            state_d     = StEval;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + FcW'(1);
          end
        end
      end
      StEval: begin
        cell_idx_d = cell_idx_q + AW'(1);
        if (cell_idx_q == AW'(SIZE - 1)) state_d = StSwap;
      end
      StSwap: begin
        sel_d       = ~sel_q;
        gen_count_d = gen_count_q + 16'd1;
        state_d     = run ? StWait : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Loads target the front buffer; evaluation only ever writes the back buffer.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (load_en && ((state_q == StIdle) || (state_q == StWait))) begin
      if (sel_q) buf1_d[load_addr] = load_data;
      else       buf0_d[load_addr] = load_data;
    end
    if (state_q == StEval) begin
      if (sel_q) buf0_d[cell_idx_q] = next_cell;
      else       buf1_d[cell_idx_q] = next_cell;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      buf0_q      <= SEED;
      buf1_q      <= '0;
      sel_q       <= 1'b0;
      frame_cnt_q <= '0;
      cell_idx_q  <= '0;
      gen_count_q <= '0;
    end else begin
      state_q     <= state_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      sel_q       <= sel_d;
      frame_cnt_q <= frame_cnt_d;
      cell_idx_q  <= cell_idx_d;
      gen_count_q <= gen_count_d;
    end
  end

endmodule

// File: tb/tb_gol_gen_scheduler.sv
// Directed self-checking bench for gol_gen_scheduler (8x8 board, 4 frames per generation).
module tb_gol_gen_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        load_en = 1'b0;
  logic [5:0]  load_addr = '0;
  logic        load_data = 1'b0;
  logic [5:0]  rd_addr = '0;
  logic        rd_data;
  logic        busy;
  logic        gen_done;
  logic [15:0] gen_count;

  int n_cmp = 0;
  int n_fail = 0;

  localparam logic [63:0] SeedVal = 64'h8;

  gol_gen_scheduler #(
    .WIDTH         (3),
    .HEIGHT        (3),
    .FRAMES_PER_GEN(4),
    .SEED          (SeedVal)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .run       (run),
    .step      (step),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .gen_done  (gen_done),
    .gen_count (gen_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_board(input string name, input logic [63:0] exp);
    logic [63:0] got;
    for (int a = 0; a < 64; a++) begin
      rd_addr = 6'(a);
      #1;
      got[a] = rd_data;
    end
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: board got %h expected %h", name, got, exp);
    end
  endtask

  task automatic load(input int addr, input logic d);
    load_en   = 1'b1;
    load_addr = 6'(addr);
    load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (gen_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  // Pulses step, returns cycles from the sampling edge to gen_done, leaves the bench at the swap.
  task automatic do_step(output int lat);
    int n;
    step = 1'b1;
    tick();
    step = 1'b0;
    chk1("busy_after_step", busy, 1'b1);
    wait_done(n);
    lat = n + 1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #3;
    check_board("reset_board", SeedVal);
    chk16("reset_gen_count", gen_count, 16'd0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_gen_done", gen_done, 1'b0);
    #20 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_blinker();
    int lat;
    logic [63:0] exp;
    load(3, 1'b0);
    load(9, 1'b1);
    load(10, 1'b1);
    load(11, 1'b1);
    exp = '0; exp[9] = 1'b1; exp[10] = 1'b1; exp[11] = 1'b1;
    check_board("blinker_loaded", exp);
    do_step(lat);
    chk16("blinker_latency", 16'(lat), 16'd65);
    chk1("blinker_gen_done", gen_done, 1'b1);
    chk1("blinker_busy_swap", busy, 1'b1);
    tick();
    exp = '0; exp[2] = 1'b1; exp[10] = 1'b1; exp[18] = 1'b1;
    check_board("blinker_gen1", exp);
    chk16("blinker_count1", gen_count, 16'd1);
    chk1("blinker_idle_busy", busy, 1'b0);
    do_step(lat);
    tick();
    exp = '0; exp[9] = 1'b1; exp[10] = 1'b1; exp[11] = 1'b1;
    check_board("blinker_gen2", exp);
    chk16("blinker_count2", gen_count, 16'd2);
  endtask

  task automatic test_edge();
    int lat;
    logic [63:0] exp;
    load(9, 1'b0);
    load(10, 1'b0);
    load(11, 1'b0);
    load(7, 1'b1);
    load(0, 1'b1);
    load(1, 1'b1);
    exp = '0; exp[7] = 1'b1; exp[0] = 1'b1; exp[1] = 1'b1;
    check_board("edge_loaded", exp);
    do_step(lat);
    tick();
    exp = '0;
`ifdef GOL_WRAP_EN
    exp[56] = 1'b1; exp[0] = 1'b1; exp[8] = 1'b1;
`endif
    check_board("edge_result", exp);
    chk16("edge_count", gen_count, 16'd3);
  endtask

  task automatic test_load_busy();
    int n;
    logic [63:0] exp;
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk1("loadbusy_busy", busy, 1'b1);
    load(20, 1'b1);
    wait_done(n);
    chk1("loadbusy_done", gen_done, 1'b1);
    tick();
    rd_addr = 6'd20;
    #1;
    chk1("loadbusy_cell20", rd_data, 1'b0);
    exp = '0;
`ifdef GOL_WRAP_EN
    exp[7] = 1'b1; exp[0] = 1'b1; exp[1] = 1'b1;
`endif
    check_board("loadbusy_board", exp);
    chk16("loadbusy_count", gen_count, 16'd4);
  endtask

  task automatic test_run_pacing();
    int n;
    run = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) pulse_tick();
    chk1("pace_busy_before_4th", busy, 1'b0);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk1("pace_busy_after_4th", busy, 1'b1);
    for (int k = 0; k < 3; k++) pulse_tick();
    wait_done(n);
    chk1("pace_gen_done1", gen_done, 1'b1);
    tick();
    chk16("pace_count1", gen_count, 16'd5);
    for (int k = 0; k < 3; k++) pulse_tick();
    chk1("pace_evalticks_dropped", busy, 1'b0);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk1("pace_busy_second", busy, 1'b1);
    tick();
    run = 1'b0;
    wait_done(n);
    chk1("pace_run_drop_completes", gen_done, 1'b1);
    tick();
    chk16("pace_count2", gen_count, 16'd6);
    for (int k = 0; k < 5; k++) pulse_tick();
    chk1("pace_idle_no_run", busy, 1'b0);
  endtask

  task automatic test_reset_mid_eval();
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 1; i < 30; i++) tick();
    chk1("rst_mid_busy_before", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("rst_mid_busy", busy, 1'b0);
    chk16("rst_mid_count", gen_count, 16'd0);
    check_board("rst_mid_board", SeedVal);
    #10 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk1("rst_mid_idle", busy, 1'b0);
    check_board("rst_mid_board_after", SeedVal);
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_edge();
    test_load_busy();
    test_run_pacing();
    test_reset_mid_eval();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
